// File: rtl/fp16_pkg.sv
// Shared FP16 field layout, special encodings and accumulator FSM states.
package fp16_pkg;

  localparam int unsigned EXP_W   = 5;
  localparam int unsigned FRAC_W  = 10;
  localparam int unsigned BIAS    = 15;
  localparam int unsigned EXP_MAX = 30;

  localparam logic [15:0] POS_INF  = 16'h7C00;
  localparam logic [15:0] NEG_INF  = 16'hFC00;
  localparam logic [15:0] POS_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StOut
  } state_e;

  function automatic logic is_inf(input logic [15:0] x);
    return x[FRAC_W +: EXP_W] == '1;
  endfunction

  // Hidden bit is set only for normal operands; exp=0 decodes as zero.
  function automatic logic [FRAC_W:0] decode_man(input logic [15:0] x);
    logic [FRAC_W:0] man;
    if (x[FRAC_W +: EXP_W] == '0) begin
      man = '0;
    end else begin
      man = {1'b1, x[FRAC_W-1:0]};
    end
    return man;
  endfunction

endpackage

// File: rtl/fp16_norm.sv
// Leading-zero count and left shift that brings bit FRAC_W of a mantissa to 1.
module fp16_norm
  import fp16_pkg::*;
(
  input  logic [FRAC_W:0] mag,
  output logic [FRAC_W:0] mag_shl,
  output logic [3:0]      lzc
);

  logic found;

  always_comb begin
    lzc   = 4'(FRAC_W + 1);
    found = 1'b0;
    for (int i = FRAC_W; i >= 0; i--) begin
      if (!found && mag[i]) begin
        lzc   = 4'(int'(FRAC_W) - i);
        found = 1'b1;
      end
    end
    // A zero input shifts out completely and leaves mag_shl[FRAC_W] clear.
    mag_shl = mag << lzc;
  end

endmodule

// File: rtl/fp16_accumulator.sv
// Packet accumulator of FP16 terms: ALIGN/ADD/NORM pipeline per term, one sum per packet.
module fp16_accumulator
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf
);

  localparam int unsigned MAN_W = FRAC_W + 1;
  localparam logic signed [EXP_W+1:0] ExpMaxS = (EXP_W + 2)'(EXP_MAX);

  state_e state_q, state_d;

  logic [15:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [15:0] opnd_q;
  logic        last_q;
  logic        in_fire;

  // ALIGN stage registers
  logic             special_q;
  logic [15:0]      special_val_q;
  logic             sign_q;
  logic             sub_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W-1:0] big_q;
  logic [MAN_W-1:0] small_q;

  // ADD stage register, one extra bit for the carry
  logic [MAN_W:0]   sum_q;

  // ALIGN combinational results
  logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp, diff;
  logic [MAN_W-1:0] a_man, b_man, big_man, small_man, small_sh;
  logic             a_big, big_sign, align_special;
  logic [15:0]      align_special_val;

  // ADD / NORM combinational results
  logic [MAN_W:0]          sum_d;
  logic [MAN_W-1:0]        norm_man;
  logic [3:0]              norm_lzc;
  logic signed [EXP_W+1:0] norm_exp;
  logic [FRAC_W-1:0]       norm_frac;
  logic [15:0]             norm_res;
  logic                    norm_ovf;

  assign in_ready  = rst_n && (state_q == StIdle);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == StOut);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    a_exp     = acc_q[FRAC_W +: EXP_W];
    b_exp     = opnd_q[FRAC_W +: EXP_W];
    a_man     = decode_man(acc_q);
    b_man     = decode_man(opnd_q);
    a_big     = {a_exp, a_man} >= {b_exp, b_man};
    big_exp   = a_big ? a_exp : b_exp;
    small_exp = a_big ? b_exp : a_exp;
    big_man   = a_big ? a_man : b_man;
    small_man = a_big ? b_man : a_man;
    big_sign  = a_big ? acc_q[15] : opnd_q[15];
    diff      = big_exp - small_exp;
    small_sh  = (diff >= 5'd12) ? '0 : (small_man >> diff);
    // An infinite accumulator wins over an infinite operand: first event sets the sign.
    align_special     = is_inf(acc_q) || is_inf(opnd_q);
    align_special_val = is_inf(acc_q) ? acc_q : (opnd_q[15] ? NEG_INF : POS_INF);
  end

  always_comb begin
    if (sub_q) begin
      sum_d = {1'b0, big_q} - {1'b0, small_q};
    end else begin
      sum_d = {1'b0, big_q} + {1'b0, small_q};
    end
  end

  fp16_norm u_norm (
    .mag     (sum_q[MAN_W-1:0]),
    .mag_shl (norm_man),
    .lzc     (norm_lzc)
  );

  always_comb begin
    norm_res  = POS_ZERO;
    norm_ovf  = 1'b0;
    norm_exp  = '0;
    norm_frac = '0;
    if (special_q) begin
      norm_res = special_val_q;
    end else if (sum_q[MAN_W] || norm_man[FRAC_W]) begin
      if (sum_q[MAN_W]) begin
        norm_exp  = signed'({2'b00, exp_q}) + (EXP_W + 2)'(1);
        norm_frac = sum_q[FRAC_W:1];
      end else begin
        norm_exp  = signed'({2'b00, exp_q}) - signed'({3'b000, norm_lzc});
        norm_frac = norm_man[FRAC_W-1:0];
      end
      if (norm_exp > ExpMaxS) begin
        norm_res = sign_q ? NEG_INF : POS_INF;
        norm_ovf = 1'b1;
      end else if (norm_exp < (EXP_W + 2)'(1)) begin
        norm_res = POS_ZERO;
      end else begin
        norm_res = {sign_q, norm_exp[EXP_W-1:0], norm_frac};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle:  if (in_fire) state_d = StAlign;
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm: begin
        acc_d   = norm_res;
        ovf_d   = ovf_q | norm_ovf;
        state_d = last_q ? StOut : StIdle;
      end
      StOut: begin
        if (out_ready) begin
          acc_d   = POS_ZERO;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      acc_q         <= POS_ZERO;
      ovf_q         <= 1'b0;
      opnd_q        <= '0;
      last_q        <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      sign_q        <= 1'b0;
      sub_q         <= 1'b0;
      exp_q         <= '0;
      big_q         <= '0;
      small_q       <= '0;
      sum_q         <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      if (in_fire) begin
        opnd_q <= in_data;
        last_q <= in_last;
      end
      if (state_q == StAlign) begin
        special_q     <= align_special;
        special_val_q <= align_special_val;
        sign_q        <= big_sign;
        sub_q         <= acc_q[15] ^ opnd_q[15];
        exp_q         <= big_exp;
        big_q         <= big_man;
        small_q       <= small_sh;
      end
      if (state_q == StAdd) begin
        sum_q <= sum_d;
      end
    end
  end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Directed and randomized packets checked against an integer-arithmetic FP16 sum model.
module tb_fp16_accumulator;
  import fp16_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  fp16_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Value-level sum of two finite FP16 numbers: align the smaller by truncating division,
  // add as signed integers, renormalise to an 11-bit mantissa. Returns {ovf, result}.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, ma, mb, e, total, mag;
    longint va, vb;
    logic [15:0] res;
    logic        ovf;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
    mb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
    va = longint'(ma) <<< ea;
    vb = longint'(mb) <<< eb;
    if (va >= vb) begin
      e     = ea;
      total = (a[15] ? -ma : ma) + (b[15] ? -(mb >> (ea - eb)) : (mb >> (ea - eb)));
    end else begin
      e     = eb;
      total = (b[15] ? -mb : mb) + (a[15] ? -(ma >> (eb - ea)) : (ma >> (eb - ea)));
    end
    res = 16'h0000;
    ovf = 1'b0;
    mag = (total < 0) ? -total : total;
    if (mag != 0) begin
      while (mag >= 2048) begin mag = mag / 2; e++; end
      while (mag < 1024) begin mag = mag * 2; e--; end
      if (e > int'(EXP_MAX)) begin
        res = (total < 0) ? 16'hFC00 : 16'h7C00;
        ovf = 1'b1;
      end else if (e >= 1) begin
        res = {total < 0, 5'(e), 10'(mag - 1024)};
      end
    end
    return {ovf, res};
  endfunction

  task automatic model_step(inout logic [15:0] acc, inout logic ovf, input logic [15:0] d);
    logic [16:0] r;
    if (acc[14:10] == 5'h1f) begin
      acc = acc;
    end else if (d[14:10] == 5'h1f) begin
      acc = d[15] ? 16'hFC00 : 16'h7C00;
    end else begin
      r   = ref_add(acc, d);
      acc = r[15:0];
      ovf = ovf | r[16];
    end
  endtask

  task automatic send_term(input logic [15:0] d, input logic l);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Call right after the last transfer; lat counts edges until out_valid is seen.
  task automatic get_result(input string tag, input logic [15:0] exp_d, input logic exp_o,
                            input int hold, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_data"}, out_data, exp_d);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
      @(posedge clk); #1;
    end
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_ovf"}, out_ovf, exp_o);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_cleared_valid"}, out_valid, 1'b0);
    check({tag, "_cleared_data"}, out_data, 16'h0000);
    check({tag, "_cleared_ovf"}, out_ovf, 1'b0);
  endtask

  function automatic logic [15:0] rand_term();
    int sel;
    int e;
    sel = $urandom_range(0, 15);
    if (sel == 0) e = 0;
    else if (sel == 1) e = 31;
    else if (sel == 2) e = $urandom_range(28, 30);
    else e = int'(BIAS) - 6 + $urandom_range(0, 12);
    return {1'($urandom), 5'(e), 10'($urandom)};
  endfunction

  // Transfer in cycle T gives out_valid in T+4, i.e. three edges after the transfer edge.
  localparam int Lat = 3;

  initial begin
    int          lat;
    int          nt;
    logic [15:0] acc;
    logic        ovf;
    logic [15:0] d;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);

    send_term(16'h3C00, 1'b0);
    send_term(16'h4000, 1'b1);
    get_result("one_plus_two", 16'h4200, 1'b0, 0, lat);
    check("one_plus_two_lat", lat, Lat);

    send_term(16'h3C00, 1'b0);
    send_term(16'hBC00, 1'b1);
    get_result("cancel", 16'h0000, 1'b0, 0, lat);

    send_term(16'h7BFF, 1'b0);
    send_term(16'h7BFF, 1'b1);
    get_result("overflow", 16'h7C00, 1'b1, 0, lat);
    send_term(16'h3C00, 1'b1);
    get_result("after_ovf", 16'h3C00, 1'b0, 0, lat);

    send_term(16'h3C00, 1'b0);
    send_term(16'h1000, 1'b1);
    get_result("truncate", 16'h3C00, 1'b0, 0, lat);
    send_term(16'h0200, 1'b1);
    get_result("subnormal", 16'h0000, 1'b0, 0, lat);

    send_term(16'h4000, 1'b1);
    get_result("backpressure", 16'h4000, 1'b0, 5, lat);

    send_term(16'h3C00, 1'b0);
    send_term(16'h4000, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_valid", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    send_term(16'h3C00, 1'b1);
    get_result("after_midrst", 16'h3C00, 1'b0, 0, lat);

    for (int p = 0; p < 40; p++) begin
      nt  = $urandom_range(1, 5);
      acc = 16'h0000;
      ovf = 1'b0;
      for (int t = 0; t < nt; t++) begin
        d = rand_term();
        model_step(acc, ovf, d);
        send_term(d, t == nt - 1);
      end
      get_result("rnd", acc, ovf, $urandom_range(0, 3), lat);
      check("rnd_lat", lat, Lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fp16_accumulator.md
FP16_ACCUMULATOR -- requirements
Module: fp16_accumulator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports `clk` and `rst_n`, with `clk` and `rst_n` listed first.
REQ-002 Ports SHALL be:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous active-low reset.
- `in_valid` input 1: product word valid.
- `in_ready` output 1: accumulator can accept a word.
- `in_data` input 16: FP16 product, {sign, exp[4:0], frac[9:0]}.
- `in_last` input 1: final term of the current sum.
- `out_valid` output 1: sum available.
- `out_ready` input 1: consumer accepts the sum.
- `out_data` output 16: FP16 sum.
- `out_ovf` output 1: sum saturated to infinity.

Function
REQ-003 The block SHALL sum a packet of FP16 products delimited by `in_last` and emit one FP16 result per packet.
REQ-004 An input transfer SHALL occur only when `in_valid` and `in_ready` are both 1; an output transfer SHALL occur only when `out_valid` and `out_ready` are both 1.
REQ-005 The FSM SHALL have five states:
- IDLE (`in_ready`=1)
- ALIGN
- ADD
- NORM
- OUT (`out_valid`=1)
REQ-006 State transitions SHALL be:
- IDLE -> ALIGN on an input transfer.
- ALIGN -> ADD -> NORM unconditionally.
- NORM -> OUT if the captured `in_last`=1, else NORM -> IDLE.
- OUT -> IDLE on an output transfer.
REQ-007 `in_ready` SHALL be 1 only in IDLE, giving a maximum throughput of one term per 4 cycles.
REQ-008 Latency from an input transfer in cycle T with `in_last`=1 SHALL be `out_valid`=1 in cycle T+4.
REQ-009 `in_data` and `in_last` SHALL be registered on the transfer; the input bus need not be held afterwards.
REQ-010 Operand decode SHALL follow these rules:
- exp=0 is treated as zero (subnormals flushed).
- exp=31 is treated as infinity, regardless of frac.
- Otherwise the mantissa is {1, frac} with bias 15.
REQ-011 ALIGN SHALL right-shift the mantissa with the smaller exponent by the exponent difference, discarding shifted-out bits (truncation, no rounding); a difference of 12 or more SHALL yield zero.
REQ-012 ADD SHALL add the magnitudes when the signs are equal, else subtract the smaller magnitude from the larger; the result takes the sign of the larger magnitude. The datapath SHALL be 12 bits wide to hold the carry.
REQ-013 NORM SHALL apply exactly one of:
- carry set: shift right 1, exp+1;
- otherwise: shift left until bit 10 is set, exp decremented by the shift count;
- magnitude zero: result is +0.
REQ-014 A normalized exp greater than 30 SHALL produce ±infinity (0x7C00/0xFC00) and set the overflow flag.
REQ-015 A normalized exp less than 1 SHALL produce +0.
REQ-016 Once the accumulator holds infinity (from an infinite input or from overflow), it SHALL stay at that signed infinity for the rest of the packet; the sign is that of the first infinity event.
REQ-017 In OUT, `out_data` and `out_ovf` SHALL be held stable until the output transfer; the accumulator and overflow flag SHALL be cleared to +0/0 on the transfer.
REQ-018 A packet of a single term SHALL output that term with zero/subnormal flushed to 0x0000.

Reset
REQ-019 With `rst_n`=0 at a rising edge, the block SHALL reset to:
- state IDLE;
- `in_ready`=0 during reset, 1 in the first cycle after release;
- `out_valid`=0;
- `out_data`=0x0000;
- `out_ovf`=0;
- accumulator and all pipeline registers 0.
REQ-020 A reset asserted mid-packet or in OUT SHALL discard the partial sum and the pending output without emitting it.

Structure
REQ-021 Shared package `fp16_pkg` SHALL hold:
- field widths (EXP_W=5, FRAC_W=10);
- BIAS=15, EXP_MAX=30;
- constants POS_INF=16'h7C00, NEG_INF=16'hFC00, POS_ZERO=16'h0000;
- the FSM state enumeration.
REQ-022 The leading-zero count and left-shift logic of REQ-013 SHALL be a combinational sub-module `fp16_norm`; everything else SHALL be in `fp16_accumulator`.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- 0x3C00, then 0x4000 with `in_last` -> `out_data`=0x4200, `out_ovf`=0, `out_valid` 4 cycles after the last transfer.
- 0x3C00, then 0xBC00 with `in_last` -> `out_data`=0x0000.
- 0x7BFF, then 0x7BFF with `in_last` -> `out_data`=0x7C00, `out_ovf`=1; a following packet 0x3C00 `in_last` -> 0x3C00, `out_ovf`=0.
- 0x3C00, then 0x1000 (2^-11) with `in_last` -> 0x3C00 (truncated); a single term 0x0200 `in_last` -> 0x0000.
- 0x4000 `in_last` with `out_ready`=0 for 5 cycles -> `out_data` stays 0x4000 and `in_ready` stays 0 until `out_ready`=1.
- `rst_n`=0 in ADD of a two-term packet -> no `out_valid`; a following 0x3C00 `in_last` -> 0x3C00.
